reg_transfer_ctrl: RTL

REG_TRANSFER_CTRL -- requirements
Module: reg_transfer_ctrl

---
 rtl/reg_transfer_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/reg_transfer_ctrl.sv
// Register-to-register transfer controller over a shared bus.
// Latency: 4 cycles per register transfer (XFER, CAPT, LOAD, return to IDLE); 2 cycles on the immediate path.
// Backpressure: cmd_ready is high only in IDLE (and low for one cycle after a rejected command).
//
// Optional feature: define XFER_IMM_EN to enable immediate loads (cmd_imm_sel/cmd_imm).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   cmd_valid/ready   command handshake; cmd_src/cmd_dst register indices
//   cmd_imm_sel/imm   immediate-load request and data (XFER_IMM_EN only)
//   bus_in            ORed register outputs, valid the cycle after a t strobe
//   t, ld             one-hot transfer-out and load strobes
//   bus_out           captured bus data driven to every register input
//   done, err         single-cycle completion / rejection pulses
module reg_transfer_ctrl #(
  parameter int W     = 16,
  parameter int NREG  = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] cmd_src,
  input  logic [IDX_W-1:0] cmd_dst,
  input  logic             cmd_imm_sel,
  input  logic [W-1:0]     cmd_imm,
  input  logic [W-1:0]     bus_in,
  output logic [NREG-1:0]  t,
  output logic [NREG-1:0]  ld,
  output logic [W-1:0]     bus_out,
  output logic             done,
  output logic             err
);

  localparam int NIDX = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    CAPT = 2'd2,
    LOAD = 2'd3
  } state_t;

  state_t          state_q;
  logic            cmd_ready_q;
  logic [NREG-1:0] t_q;
  logic [NREG-1:0] ld_q;
  logic [NREG-1:0] dst_oh_q;
  logic [W-1:0]    bus_out_q;
  logic            done_q;
  logic            err_q;

  logic [NIDX-1:0] idx_ok;
  logic [NREG-1:0] src_oh_d;
  logic [NREG-1:0] dst_oh_d;
  logic            src_ok_d;
  logic            dst_ok_d;
  logic            hs_d;
  logic            imm_path_d;

  function automatic logic [NREG-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREG; i++) begin
      oh[i] = (idx == IDX_W'(i));
    end
    return oh;
  endfunction

  // Range table indexed by the raw index avoids width-limited compares
  // when NREG fills the whole index space.
  always_comb begin
    idx_ok = '0;
    for (int i = 0; i < NIDX; i++) begin
      idx_ok[i] = (i < NREG);
    end
  end

  always_comb begin
    hs_d     = cmd_valid & cmd_ready_q;
    src_ok_d = idx_ok[cmd_src];
    dst_ok_d = idx_ok[cmd_dst];
    src_oh_d = idx_onehot(cmd_src);
    dst_oh_d = idx_onehot(cmd_dst);
`ifdef XFER_IMM_EN
    imm_path_d = cmd_imm_sel;
`else
    imm_path_d = 1'b0;
`endif
  end

`ifndef XFER_IMM_EN
  // Immediate inputs have no function in this build.
  logic unused_imm;
  assign unused_imm = ^{cmd_imm_sel, cmd_imm};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      t_q         <= '0;
      ld_q        <= '0;
      dst_oh_q    <= '0;
      bus_out_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Strobes and pulses default low; each is set for a single cycle below.
      t_q    <= '0;
      ld_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Re-arms ready after the one-cycle drop that follows a rejection.
          cmd_ready_q <= 1'b1;
          if (hs_d) begin
            cmd_ready_q <= 1'b0;
            if (imm_path_d) begin
`ifdef XFER_IMM_EN
              if (dst_ok_d) begin
                state_q   <= LOAD;
                bus_out_q <= cmd_imm;
                ld_q      <= dst_oh_d;
                done_q    <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
`endif
            end else if (src_ok_d && dst_ok_d) begin
              // t is issued from the live source index; only the
              // destination needs to survive until LOAD.
              state_q  <= XFER;
              t_q      <= src_oh_d;
              dst_oh_q <= dst_oh_d;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        XFER: begin
          state_q <= CAPT;
        end
        CAPT: begin
          // bus_in now reflects the register strobed during XFER.
          state_q   <= LOAD;
          bus_out_q <= bus_in;
          ld_q      <= dst_oh_q;
          done_q    <= 1'b1;
        end
        LOAD: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign t         = t_q;
  assign ld        = ld_q;
  assign bus_out   = bus_out_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
